ofs_plat_utils_avalon_mm_burst_responder: RTL

Single-clock Avalon-MM bursting slave endpoint backed by a local RAM window. It terminates the command stream a clock-crossing bridge emits on its master side: it accepts read and write bursts, commits writes with byteenable, and returns read bursts on readdatavalid with no response backpressure. It serves as the far-end responder for bridge/shim benches and as a small scratchpad behind platform CSR/host channels.

---
 rtl/ofs_plat_utils_avalon_mm_burst_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ofs_plat_utils_avalon_mm_burst_responder.sv
// Avalon-MM bursting slave backed by a local RAM window: write bursts with byteenable,
// queued read bursts returned in command order on readdatavalid with registered RAM output.
module ofs_plat_utils_avalon_mm_burst_responder #(
   parameter int DATA_WIDTH       = 32,
   parameter int SYMBOL_WIDTH     = 8,
   parameter int ADDR_WIDTH       = 8,
   parameter int BURSTCOUNT_WIDTH = 4,
   parameter int READ_CMD_DEPTH   = 4
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   output logic                                   s_waitrequest,
   input  logic [ADDR_WIDTH-1:0]                  s_address,
   input  logic [BURSTCOUNT_WIDTH-1:0]            s_burstcount,
   input  logic                                   s_read,
   input  logic                                   s_write,
   input  logic [DATA_WIDTH-1:0]                  s_writedata,
   input  logic [DATA_WIDTH/SYMBOL_WIDTH-1:0]     s_byteenable,
   output logic [DATA_WIDTH-1:0]                  s_readdata,
   output logic                                   s_readdatavalid,
   output logic [$clog2(READ_CMD_DEPTH):0]        rd_cmd_count,
   output logic                                   err_protocol
);

   localparam int BYTEEN_WIDTH = DATA_WIDTH / SYMBOL_WIDTH;
   localparam int QAW          = $clog2(READ_CMD_DEPTH);
   localparam int MAX_BURST    = 2 ** (BURSTCOUNT_WIDTH - 1);

   typedef logic [ADDR_WIDTH-1:0]       addr_t;
   typedef logic [BURSTCOUNT_WIDTH-1:0] bc_t;
   typedef logic [QAW:0]                ptr_t;
   typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;

   localparam bc_t MAX_BC = bc_t'(MAX_BURST);

   logic      in_reset_reg;
   wr_state_t wr_state_reg, wr_state_next;
   addr_t     wr_addr_reg, wr_addr_next;
   bc_t       wr_remain_reg, wr_remain_next;
   addr_t     mem_wr_addr;

   addr_t     q_addr_mem [READ_CMD_DEPTH];
   bc_t       q_bc_mem   [READ_CMD_DEPTH];
   ptr_t      q_wr_ptr_reg, q_rd_ptr_reg;
   ptr_t      q_occ;
   logic      q_full, q_empty, q_pop;
   addr_t     head_addr;
   bc_t       head_bc;

   logic      rd_active_reg, rd_active_next;
   addr_t     rd_addr_reg, rd_addr_next;
   bc_t       rd_remain_reg, rd_remain_next;
   logic      rd_issue;
   addr_t     ram_rd_addr;

   logic      wr_acc, rd_acc, bc_bad, err_next;
   bc_t       bc_norm;

   // Flop releases one edge after reset_n rises so the first command lands cleanly
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) in_reset_reg <= 1'b1;
      else          in_reset_reg <= 1'b0;
   end

   assign q_occ     = q_wr_ptr_reg - q_rd_ptr_reg;
   assign q_full    = (q_occ == ptr_t'(READ_CMD_DEPTH));
   assign q_empty   = (q_occ == '0);
   assign head_addr = q_addr_mem[q_rd_ptr_reg[QAW-1:0]];
   assign head_bc   = q_bc_mem[q_rd_ptr_reg[QAW-1:0]];

   assign s_waitrequest = in_reset_reg | (s_read & (q_full | (wr_state_reg == WR_BURST)));
   assign wr_acc        = s_write & ~s_waitrequest;
   assign rd_acc        = s_read & ~s_write & ~s_waitrequest;

   always_comb begin
      bc_bad  = (s_burstcount == '0) || (s_burstcount > MAX_BC);
      bc_norm = s_burstcount;
      if (s_burstcount == '0)        bc_norm = bc_t'(1);
      else if (s_burstcount > MAX_BC) bc_norm = MAX_BC;
   end

   always_comb begin
      wr_state_next  = wr_state_reg;
      wr_addr_next   = wr_addr_reg;
      wr_remain_next = wr_remain_reg;
      mem_wr_addr    = wr_addr_reg;
      case (wr_state_reg)
         WR_IDLE: begin
            mem_wr_addr = s_address;
            if (wr_acc) begin
               wr_addr_next   = s_address + addr_t'(1);
               wr_remain_next = bc_norm - bc_t'(1);
               if (bc_norm > bc_t'(1)) wr_state_next = WR_BURST;
            end
         end
         WR_BURST: begin
            if (wr_acc) begin
               wr_addr_next   = wr_addr_reg + addr_t'(1);
               wr_remain_next = wr_remain_reg - bc_t'(1);
               if (wr_remain_reg == bc_t'(1)) wr_state_next = WR_IDLE;
            end
         end
         default: wr_state_next = WR_IDLE;
      endcase
   end

   // Idle engine pops the head and reads its first word in the same cycle, so
   // consecutive bursts stream with no bubble.
   always_comb begin
      rd_active_next = rd_active_reg;
      rd_addr_next   = rd_addr_reg;
      rd_remain_next = rd_remain_reg;
      q_pop          = 1'b0;
      rd_issue       = 1'b0;
      ram_rd_addr    = rd_addr_reg;
      if (rd_active_reg) begin
         rd_issue       = 1'b1;
         rd_addr_next   = rd_addr_reg + addr_t'(1);
         rd_remain_next = rd_remain_reg - bc_t'(1);
         rd_active_next = (rd_remain_reg != bc_t'(1));
      end else if (!q_empty) begin
         q_pop          = 1'b1;
         rd_issue       = 1'b1;
         ram_rd_addr    = head_addr;
         rd_addr_next   = head_addr + addr_t'(1);
         rd_remain_next = head_bc - bc_t'(1);
         rd_active_next = (head_bc > bc_t'(1));
      end
   end

   assign err_next = err_protocol | (s_read & s_write & ~s_waitrequest) |
                     (bc_bad & (rd_acc | (wr_acc & (wr_state_reg == WR_IDLE))));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_state_reg    <= WR_IDLE;
         wr_addr_reg     <= '0;
         wr_remain_reg   <= '0;
         q_wr_ptr_reg    <= '0;
         q_rd_ptr_reg    <= '0;
         rd_active_reg   <= 1'b0;
         rd_addr_reg     <= '0;
         rd_remain_reg   <= '0;
         s_readdatavalid <= 1'b0;
         err_protocol    <= 1'b0;
      end else begin
         wr_state_reg    <= wr_state_next;
         wr_addr_reg     <= wr_addr_next;
         wr_remain_reg   <= wr_remain_next;
         q_wr_ptr_reg    <= q_wr_ptr_reg + ptr_t'(rd_acc);
         q_rd_ptr_reg    <= q_rd_ptr_reg + ptr_t'(q_pop);
         rd_active_reg   <= rd_active_next;
         rd_addr_reg     <= rd_addr_next;
         rd_remain_reg   <= rd_remain_next;
         s_readdatavalid <= rd_issue;
         err_protocol    <= err_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_acc) begin
         q_addr_mem[q_wr_ptr_reg[QAW-1:0]] <= s_address;
         q_bc_mem[q_wr_ptr_reg[QAW-1:0]]   <= bc_norm;
      end
   end

   assign rd_cmd_count = q_occ + {{QAW{1'b0}}, rd_active_reg};

   // One RAM bank per byte lane keeps byteenable writes inferable as block RAM
   genvar gi;
   generate
      for (gi = 0; gi < BYTEEN_WIDTH; gi++) begin : g_lane
         logic [SYMBOL_WIDTH-1:0] lane_mem [2**ADDR_WIDTH];
         logic [SYMBOL_WIDTH-1:0] lane_rdata_reg;

         always_ff @(posedge clk) begin
            if (wr_acc && s_byteenable[gi])
               lane_mem[mem_wr_addr] <= s_writedata[gi*SYMBOL_WIDTH +: SYMBOL_WIDTH];
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)      lane_rdata_reg <= '0;
            else if (rd_issue) lane_rdata_reg <= lane_mem[ram_rd_addr];
         end

         assign s_readdata[gi*SYMBOL_WIDTH +: SYMBOL_WIDTH] = lane_rdata_reg;
      end
   endgenerate

endmodule
